// File: rtl/aes_axi4lite_pkg.sv
// Shared constants for the AES AXI4-lite control block:
// register offsets, bit indices, FSM states, responses.
package aes_axi4lite_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CLR    = 8'h08;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_PT     = 8'h30;
  localparam logic [7:0] OFF_CT     = 8'h40;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_DONE    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_TIMEOUT = 2;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_RUN  = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic ctrl;
    logic stat;
    logic clr;
    logic key;
    logic pt;
    logic ct;
  } sel_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_axi4lite_regif.sv
// AXI4-lite slave handshake, address decode and read mux.
// Ports: AXI channels, register views in, write strobes out.
module aes_axi4lite_regif
  import aes_axi4lite_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int KEY_WORDS   = 6,
  parameter int BLOCK_WORDS = 4,
  parameter int KIW         = $clog2(KEY_WORDS),
  parameter int BIW         = $clog2(BLOCK_WORDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AW-1:0]            i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [DW-1:0]            i_axi_wdata,
  input  logic [DW/8-1:0]          i_axi_wstrb,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AW-1:0]            i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [DW-1:0]            o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  input  logic                     busy_i,
  input  logic                     irq_en_i,
  input  logic                     done_i,
  input  logic                     timeout_i,
  input  logic [32*KEY_WORDS-1:0]  key_i,
  input  logic [32*BLOCK_WORDS-1:0] pt_i,
  input  logic [32*BLOCK_WORDS-1:0] ct_i,
  output logic                     wr_ctrl_o,
  output logic                     wr_clr_o,
  output logic                     wr_key_o,
  output logic                     wr_pt_o,
  output logic [KIW-1:0]           wr_kidx_o,
  output logic [BIW-1:0]           wr_pidx_o,
  output logic [31:0]              wdata_o,
  output logic [3:0]               wstrb_o
);

  localparam logic [5:0] W_CTRL = OFF_CTRL[7:2];
  localparam logic [5:0] W_STAT = OFF_STATUS[7:2];
  localparam logic [5:0] W_CLR  = OFF_CLR[7:2];
  localparam logic [5:0] W_KEY  = OFF_KEY[7:2];
  localparam logic [5:0] W_PT   = OFF_PT[7:2];
  localparam logic [5:0] W_CT   = OFF_CT[7:2];
  localparam logic [5:0] W_KEND = W_KEY + 6'(KEY_WORDS);
  localparam logic [5:0] W_PEND = W_PT + 6'(BLOCK_WORDS);
  localparam logic [5:0] W_CEND = W_CT + 6'(BLOCK_WORDS);

  function automatic sel_t dec(input logic [5:0] w);
    sel_t s;
    s.ctrl = (w == W_CTRL);
    s.stat = (w == W_STAT);
    s.clr  = (w == W_CLR);
    s.key  = (w >= W_KEY) && (w < W_KEND);
    s.pt   = (w >= W_PT) && (w < W_PEND);
    s.ct   = (w >= W_CT) && (w < W_CEND);
    return s;
  endfunction

  logic [5:0]  aw_w;
  logic [5:0]  ar_w;
  sel_t        ws;
  sel_t        rs;
  logic        aw_hs;
  logic        ar_hs;
  logic        start_req;
  logic        busy_err;
  logic        wr_ok;
  logic [1:0]  wr_resp;
  logic [1:0]  rd_resp;
  logic [DW-1:0] rd_data;
  logic [KIW-1:0] rd_kidx;
  logic [BIW-1:0] rd_pidx;
  logic unused_addr;

  logic [31:0] key_w [KEY_WORDS];
  logic [31:0] pt_w  [BLOCK_WORDS];
  logic [31:0] ct_w  [BLOCK_WORDS];

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_kw
    assign key_w[i] = key_i[32*i +: 32];
  end

  // CT is presented most significant word first
  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_bw
    assign pt_w[i] = pt_i[32*i +: 32];
    assign ct_w[i] = ct_i[32*(BLOCK_WORDS-1-i) +: 32];
  end

  assign unused_addr = ^{i_axi_awaddr[AW-1:8], i_axi_awaddr[1:0],
                         i_axi_araddr[AW-1:8], i_axi_araddr[1:0]};

  assign aw_w = i_axi_awaddr[7:2];
  assign ar_w = i_axi_araddr[7:2];
  assign ws   = dec(aw_w);
  assign rs   = dec(ar_w);

  // write accepted only with both channels present, no B pending
  assign aw_hs = rst_ni & i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid;
  assign o_axi_awready = aw_hs;
  assign o_axi_wready  = aw_hs;

  assign start_req = ws.ctrl & i_axi_wstrb[0] & i_axi_wdata[CTRL_START];
  assign busy_err  = busy_i & (ws.key | ws.pt | start_req);

  always_comb begin
    wr_resp = RESP_OKAY;
    if (!(|ws))        wr_resp = RESP_DECERR;
    else if (busy_err) wr_resp = RESP_SLVERR;
  end

  assign wr_ok     = aw_hs & (|ws) & ~busy_err;
  assign wr_ctrl_o = wr_ok & ws.ctrl;
  assign wr_clr_o  = wr_ok & ws.clr;
  assign wr_key_o  = wr_ok & ws.key;
  assign wr_pt_o   = wr_ok & ws.pt;
  assign wr_kidx_o = KIW'(aw_w - W_KEY);
  assign wr_pidx_o = BIW'(aw_w - W_PT);
  assign wdata_o   = i_axi_wdata;
  assign wstrb_o   = i_axi_wstrb;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      o_axi_bvalid <= 1'b0;
      o_axi_bresp  <= 2'b00;
    end else if (aw_hs) begin
      o_axi_bvalid <= 1'b1;
      o_axi_bresp  <= wr_resp;
    end else if (i_axi_bready) begin
      o_axi_bvalid <= 1'b0;
    end
  end

  assign rd_kidx = KIW'(ar_w - W_KEY);
  assign rd_pidx = (rs.ct) ? BIW'(ar_w - W_CT) : BIW'(ar_w - W_PT);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    unique case (1'b1)
      rs.ctrl: rd_data[CTRL_IRQ_EN] = irq_en_i;
      rs.stat: begin
        rd_data[ST_DONE]    = done_i;
        rd_data[ST_BUSY]    = busy_i;
        rd_data[ST_TIMEOUT] = timeout_i;
      end
      rs.clr:  rd_data = '0;
      rs.key:  rd_data = key_w[rd_kidx];
      rs.pt:   rd_data = pt_w[rd_pidx];
      rs.ct:   rd_data = ct_w[rd_pidx];
      default: rd_resp = RESP_DECERR;
    endcase
  end

  assign o_axi_arready = rst_ni & ~o_axi_rvalid;
  assign ar_hs = i_axi_arvalid & o_axi_arready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      o_axi_rvalid <= 1'b0;
      o_axi_rdata  <= '0;
      o_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      o_axi_rvalid <= 1'b1;
      o_axi_rdata  <= rd_data;
      o_axi_rresp  <= rd_resp;
    end else if (i_axi_rready) begin
      o_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_axi4lite_ctrl.sv
// AES core controller: key/PT/CT registers, start FSM, timeout.
// Ports: AXI4-lite slave, cipher core handshake, level irq.
module aes_axi4lite_ctrl
  import aes_axi4lite_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int KEY_WORDS      = 6,
  parameter int BLOCK_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AW-1:0]             i_axi_awaddr,
  input  logic                      i_axi_awvalid,
  output logic                      o_axi_awready,
  input  logic [DW-1:0]             i_axi_wdata,
  input  logic [DW/8-1:0]           i_axi_wstrb,
  input  logic                      i_axi_wvalid,
  output logic                      o_axi_wready,
  output logic [1:0]                o_axi_bresp,
  output logic                      o_axi_bvalid,
  input  logic                      i_axi_bready,
  input  logic [AW-1:0]             i_axi_araddr,
  input  logic                      i_axi_arvalid,
  output logic                      o_axi_arready,
  output logic [DW-1:0]             o_axi_rdata,
  output logic [1:0]                o_axi_rresp,
  output logic                      o_axi_rvalid,
  input  logic                      i_axi_rready,
  output logic                      core_start_o,
  output logic [32*KEY_WORDS-1:0]   core_key_o,
  output logic [32*BLOCK_WORDS-1:0] core_pt_o,
  input  logic [32*BLOCK_WORDS-1:0] core_ct_i,
  input  logic                      core_done_i,
  output logic                      irq_o
);

  localparam int KIW = $clog2(KEY_WORDS);
  localparam int BIW = $clog2(BLOCK_WORDS);
  localparam int CW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [32*KEY_WORDS-1:0]  key_q;
  logic [32*BLOCK_WORDS-1:0] pt_q;
  logic [32*BLOCK_WORDS-1:0] ct_q;
  logic                     irq_en_q;
  logic                     done_q;
  logic                     tout_q;
  logic                     irq_q;
  logic                     start_q;

  logic                     busy;
  logic                     start_go;
  logic                     wr_ctrl;
  logic                     wr_clr;
  logic                     wr_key;
  logic                     wr_pt;
  logic [KIW-1:0]           wr_kidx;
  logic [BIW-1:0]           wr_pidx;
  logic [31:0]              wdata;
  logic [3:0]               wstrb;

  aes_axi4lite_regif #(
    .AW          (AW),
    .DW          (DW),
    .KEY_WORDS   (KEY_WORDS),
    .BLOCK_WORDS (BLOCK_WORDS),
    .KIW         (KIW),
    .BIW         (BIW)
  ) u_regif (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awvalid (i_axi_awvalid),
    .o_axi_awready (o_axi_awready),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wstrb   (i_axi_wstrb),
    .i_axi_wvalid  (i_axi_wvalid),
    .o_axi_wready  (o_axi_wready),
    .o_axi_bresp   (o_axi_bresp),
    .o_axi_bvalid  (o_axi_bvalid),
    .i_axi_bready  (i_axi_bready),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arvalid (i_axi_arvalid),
    .o_axi_arready (o_axi_arready),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rresp   (o_axi_rresp),
    .o_axi_rvalid  (o_axi_rvalid),
    .i_axi_rready  (i_axi_rready),
    .busy_i        (busy),
    .irq_en_i      (irq_en_q),
    .done_i        (done_q),
    .timeout_i     (tout_q),
    .key_i         (key_q),
    .pt_i          (pt_q),
    .ct_i          (ct_q),
    .wr_ctrl_o     (wr_ctrl),
    .wr_clr_o      (wr_clr),
    .wr_key_o      (wr_key),
    .wr_pt_o       (wr_pt),
    .wr_kidx_o     (wr_kidx),
    .wr_pidx_o     (wr_pidx),
    .wdata_o       (wdata),
    .wstrb_o       (wstrb)
  );

  assign busy     = (state_q == S_RUN);
  assign start_go = wr_ctrl & wstrb[0] & wdata[CTRL_START];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      key_q    <= '0;
      pt_q     <= '0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_ctrl && wstrb[0])
        irq_en_q <= wdata[CTRL_IRQ_EN];
      for (int i = 0; i < KEY_WORDS; i++)
        if (wr_key && wr_kidx == KIW'(i))
          key_q[32*i +: 32] <=
            strb_merge(key_q[32*i +: 32], wdata, wstrb);
      for (int i = 0; i < BLOCK_WORDS; i++)
        if (wr_pt && wr_pidx == BIW'(i))
          pt_q[32*i +: 32] <=
            strb_merge(pt_q[32*i +: 32], wdata, wstrb);
    end
  end

  // clear is applied first so a completion in RUN overrides it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (wr_clr) begin
        if (wdata[ST_DONE])    done_q <= 1'b0;
        if (wdata[ST_TIMEOUT]) tout_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start_go) begin
            start_q <= 1'b1;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (core_done_i) begin
            ct_q    <= core_ct_i;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            tout_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_en_q & (done_q | tout_q);
  end

  assign core_start_o = start_q;
  assign core_key_o   = key_q;
  assign core_pt_o    = pt_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_aes_axi4lite_ctrl.sv
// Directed bench for aes_axi4lite_ctrl: register table plus
// start/done/timeout/reset sequences against a stub core.
module tb_aes_axi4lite_ctrl;

  localparam int KW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          core_start;
  logic [32*KW-1:0] core_key;
  logic [32*BW-1:0] core_pt;
  logic [32*BW-1:0] ct_in = '0;
  logic          core_done = 1'b0;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int stub_delay = 0;

  always #5 clk = ~clk;

  aes_axi4lite_ctrl #(
    .AW(32), .DW(32), .KEY_WORDS(KW), .BLOCK_WORDS(BW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid),
    .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid),
    .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
    .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .core_start_o(core_start), .core_key_o(core_key),
    .core_pt_o(core_pt), .core_ct_i(ct_in),
    .core_done_i(core_done), .irq_o(irq)
  );

  always @(posedge clk)
    if (core_start === 1'b1) n_start <= n_start + 1;

  // stub core: done is sampled by the DUT stub_delay cycles
  // after the edge that first sees the start pulse
  initial begin
    forever begin
      @(posedge clk);
      if (core_start === 1'b1 && stub_delay > 0) begin
        repeat (stub_delay - 1) @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no handshake, required one", name);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) bound_fail("aw handshake");
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) bound_fail("b response");
    resp = bresp;
    @(posedge clk);
    #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) bound_fail("ar handshake");
    @(posedge clk);
    #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) bound_fail("r response");
    d = rdata;
    resp = rresp;
    @(posedge clk);
    #1 rready = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] kv [KW];
  logic [31:0] pv [BW];
  logic [31:0] cv [BW];
  logic [31:0] d;
  logic [1:0]  r;
  int s0;

  initial begin
    vecs = '{
      '{32'h10, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 2'b00},
      '{32'h10, 32'hAABBCCDD, 4'h5, 2'b00, 32'h11BB33DD, 2'b00},
      '{32'h24, 32'h01020304, 4'hF, 2'b00, 32'h01020304, 2'b00},
      '{32'h28, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h00000000, 2'b11},
      '{32'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 2'b00},
      '{32'h30, 32'h12345678, 4'hC, 2'b00, 32'h12340000, 2'b00},
      '{32'h00, 32'h00000002, 4'hF, 2'b00, 32'h00000002, 2'b00},
      '{32'h00, 32'h00000000, 4'h2, 2'b00, 32'h00000002, 2'b00},
      '{32'h00, 32'h00000000, 4'h1, 2'b00, 32'h00000000, 2'b00},
      '{32'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00000000, 2'b00},
      '{32'h40, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00000000, 2'b00},
      '{32'h50, 32'h00000001, 4'hF, 2'b11, 32'h00000000, 2'b11},
      '{32'h80, 32'h00000001, 4'hF, 2'b11, 32'h00000000, 2'b11},
      '{32'h0C, 32'h00000001, 4'hF, 2'b11, 32'h00000000, 2'b11},
      '{32'h08, 32'h00000007, 4'hF, 2'b00, 32'h00000000, 2'b00}
    };
    kv = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588,
           32'h09cf4f3c, 32'h2b7e1516, 32'h28aed2a6};
    pv = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
    cv = '{32'h4fcb8db8, 32'h5784a2c1, 32'hbb77db7e, 32'hde3217ac};

    // reset
    cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst awready", awready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst irq", irq, 0);
    chk("rst start", core_start, 0);
    chk("rst key", core_key, 0);
    chk("rst pt", core_pt, 0);
    cycles(1);

    // register table
    for (int i = 0; i < 15; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
      chk($sformatf("vec%0d bresp", i), r, vecs[i].bresp);
      axi_read(vecs[i].addr, d, r);
      chk($sformatf("vec%0d rdata", i), d, vecs[i].rdata);
      chk($sformatf("vec%0d rresp", i), r, vecs[i].rresp);
    end

    // full encryption with a 12-cycle core
    for (int i = 0; i < KW; i++) begin
      axi_write(32'h24 - 32'(4*i), kv[i], 4'hF, r);
      chk($sformatf("key%0d bresp", i), r, 2'b00);
    end
    for (int i = 0; i < BW; i++) begin
      axi_write(32'h3C - 32'(4*i), pv[i], 4'hF, r);
      chk($sformatf("pt%0d bresp", i), r, 2'b00);
    end
    chk("core_key", core_key,
        192'h2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6);
    chk("core_pt", core_pt,
        128'h3243f6a8_885a308d_313198a2_e0370734);
    stub_delay = 12;
    ct_in = 128'h4fcb8db8_5784a2c1_bb77db7e_de3217ac;
    s0 = n_start;
    axi_write(32'h00, 32'h3, 4'h1, r);
    chk("start bresp", r, 2'b00);
    axi_read(32'h04, d, r);
    chk("status busy", d, 32'h2);
    axi_write(32'h30, 32'hdeadbeef, 4'hF, r);
    chk("pt busy bresp", r, 2'b10);
    axi_read(32'h30, d, r);
    chk("pt busy readback", d, 32'he0370734);
    cycles(20);
    axi_read(32'h04, d, r);
    chk("status done", d, 32'h1);
    chk("irq done", irq, 1);
    chk("start pulses", n_start - s0, 1);
    ct_in = 128'h0;
    for (int i = 0; i < BW; i++) begin
      axi_read(32'h40 + 32'(4*i), d, r);
      chk($sformatf("ct%0d", i), d, cv[i]);
    end
    axi_write(32'h08, 32'h1, 4'hF, r);
    axi_read(32'h04, d, r);
    chk("status cleared", d, 32'h0);
    cycles(2);
    chk("irq cleared", irq, 0);

    // core never completes
    stub_delay = 0;
    s0 = n_start;
    axi_write(32'h00, 32'h3, 4'h1, r);
    axi_read(32'h04, d, r);
    chk("to busy", d, 32'h2);
    axi_write(32'h00, 32'h3, 4'h1, r);
    chk("start busy bresp", r, 2'b10);
    cycles(25);
    axi_read(32'h04, d, r);
    chk("status timeout", d, 32'h4);
    chk("irq timeout", irq, 1);
    chk("to start pulses", n_start - s0, 1);
    axi_write(32'h08, 32'h4, 4'hF, r);
    axi_read(32'h04, d, r);
    chk("timeout cleared", d, 32'h0);

    // done on the expiry cycle wins
    stub_delay = 15;
    ct_in = 128'h01234567_89abcdef_fedcba98_76543210;
    axi_write(32'h00, 32'h3, 4'h1, r);
    cycles(30);
    axi_read(32'h04, d, r);
    chk("coincide status", d, 32'h1);
    axi_read(32'h40, d, r);
    chk("coincide ct0", d, 32'h01234567);

    // done one cycle after expiry is ignored
    stub_delay = 16;
    ct_in = 128'h55555555_66666666_77777777_88888888;
    axi_write(32'h00, 32'h3, 4'h1, r);
    cycles(30);
    axi_read(32'h04, d, r);
    chk("late done status", d, 32'h4);
    axi_read(32'h40, d, r);
    chk("late done ct0", d, 32'h01234567);

    // reset mid-run with a pending B beat
    stub_delay = 0;
    axi_write(32'h00, 32'h3, 4'h1, r);
    awaddr = 32'h08; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 50 && !awready; n++) @(negedge clk);
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("b pending", bvalid, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst bvalid after", bvalid, 0);
    cycles(4);
    @(negedge clk);
    chk("bvalid stays low", bvalid, 0);
    chk("irq after rst", irq, 0);
    cycles(1);
    axi_read(32'h04, d, r);
    chk("status after rst", d, 32'h0);
    axi_read(32'h10, d, r);
    chk("key0 after rst", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_axi4lite_ctrl.md
AES_AXI4LITE_CTRL -- requirements
Module: aes_axi4lite_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32: AXI4-lite address width.
REQ-002 SHALL have parameter DW, default 32: AXI4-lite data width; only 32 is supported.
REQ-003 SHALL have parameter KEY_WORDS, default 6: key length in 32-bit words; legal values are 4, 6 and 8.
REQ-004 SHALL have parameter BLOCK_WORDS, default 4: cipher block length in 32-bit words.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum core busy time before abort.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL provide the AXI4-lite slave channels AW (awaddr AW bits, awvalid, awready), W (wdata DW, wstrb DW/8, wvalid, wready), B (bresp 2, bvalid, bready), AR (araddr AW, arvalid, arready) and R (rdata DW, rresp 2, rvalid, rready), with the o_axi_/i_axi_ port prefixes.
REQ-009 SHALL have port core_start_o, output, 1 bit: single-cycle start pulse to the cipher core.
REQ-010 SHALL have port core_key_o, output, 32*KEY_WORDS bits: key held for the core.
REQ-011 SHALL have port core_pt_o, output, 32*BLOCK_WORDS bits: plaintext held for the core.
REQ-012 SHALL have port core_ct_i, input, 32*BLOCK_WORDS bits: ciphertext from the core.
REQ-013 SHALL have port core_done_i, input, 1 bit: core completion pulse.
REQ-014 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-015 SHALL decode this byte map, using address bits [7:0]:
  - 0x00 CTRL: bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN, read/write.
  - 0x04 STATUS: bit0 DONE, bit1 BUSY, bit2 TIMEOUT; read-only.
  - 0x08 STATUS clear: writing 1 clears the corresponding STATUS bit.
  - 0x10+4i KEY[i]: 32 bits, i < KEY_WORDS; KEY[i] maps to core_key_o[32i+31:32i].
  - 0x30+4i PT[i]: same mapping onto core_pt_o.
  - 0x40+4i CT[i]: read-only; returns core_ct word (BLOCK_WORDS-1-i), so the most significant word is at the lowest address.
REQ-016 SHALL accept a write only when awvalid and wvalid are both high and no B response is pending; awready and wready SHALL pulse together for one cycle, and bvalid SHALL assert on the next cycle and hold until bready.
REQ-017 SHALL honour wstrb per byte for the KEY, PT and CTRL registers.
REQ-018 SHALL accept a read only when no R response is pending; rdata and rvalid SHALL be registered one cycle after the AR handshake, and rvalid SHALL hold until rready.
REQ-019 SHALL return resp DECERR (2'b11) for unmapped addresses; such writes SHALL be ignored and such reads SHALL return 0.
REQ-020 SHALL return SLVERR (2'b10) for a write to KEY, PT or START while BUSY, and SHALL leave the registers unchanged.
REQ-021 SHALL implement FSM IDLE -> RUN -> IDLE:
  - IDLE + START written: core_start_o pulses for one cycle, BUSY is set, DONE and TIMEOUT are cleared, the timeout counter is zeroed, and the FSM moves to RUN.
  - RUN + core_done_i: the ciphertext is latched into an internal CT register, DONE is set, BUSY is cleared, and the FSM moves to IDLE.
  - RUN with the counter reaching TIMEOUT_CYCLES-1 and no core_done_i: TIMEOUT is set, BUSY is cleared, and the FSM moves to IDLE.
REQ-022 SHALL give core_done_i priority when it arrives on the same cycle as the timeout expiry; DONE is then set and TIMEOUT is not.
REQ-023 SHALL ignore core_done_i while IDLE.
REQ-024 SHALL let a STATUS clear take priority over a concurrent set of the same bit only while IDLE; a set caused by a completion in RUN wins over a clear.
REQ-025 SHALL drive irq_o = IRQ_EN & (DONE | TIMEOUT), registered.
REQ-026 SHALL make CT reads return the latched ciphertext, stable until the next completion.

Reset
REQ-027 SHALL, while rst_ni is low at a clock edge, set the FSM to IDLE and clear all registers to 0 (KEY, PT, CT, CTRL, STATUS, counter).
REQ-028 SHALL, on the same reset, set all ready and valid outputs, core_start_o and irq_o to 0, and bresp, rresp and rdata to 0.
REQ-029 SHALL abandon an in-flight operation or AXI response when reset is asserted mid-operation, with no B or R beat issued afterwards.

Structure
REQ-030 SHALL place the register offsets, the STATUS and CTRL bit indices, the FSM state typedef and the response encodings in the shared package aes_axi4lite_pkg.
REQ-031 SHALL contain one sub-module, aes_axi4lite_regif, holding the AXI4-lite handshake and address decode; the FSM, counter and registers SHALL live in the top module.

Verification
REQ-032 SHALL cover: with KEY_WORDS=6, write key 2b7e1516 28aed2a6 abf71588 09cf4f3c 2b7e1516 28aed2a6 with word 0 at 0x24 down to 0x10, and PT 3243f6a8 885a308d 313198a2 e0370734 to 0x3C..0x30, then START; a stub core finishing after 12 cycles with ct 4fcb8db8_5784a2c1_bb77db7e_de3217ac -> STATUS reads 0x1, CT reads at 0x40..0x4C return 4fcb8db8, 5784a2c1, bb77db7e, de3217ac.
REQ-033 SHALL cover a PT write during BUSY -> bresp 2'b10, and the PT readback is unchanged.
REQ-034 SHALL cover a stub core that never completes, with TIMEOUT_CYCLES=16 -> STATUS reads 0x4 after 16 cycles, and irq_o is high when IRQ_EN=1.
REQ-035 SHALL cover a read of 0x80 -> rresp 2'b11 and rdata 0, and a write to 0x80 -> bresp 2'b11.
REQ-036 SHALL cover core_done_i on the timeout-expiry cycle -> STATUS reads 0x1.
REQ-037 SHALL cover reset asserted in RUN with bready held low -> bvalid is 0 and STATUS reads 0 after release.
